// File: rtl/csr_ctrl.sv
// Machine-mode CSR file + trap/MRET/WFI sequencer for a single-issue in-order core.
// Latency: csr_rdata is combinational; redirect asserts one cycle after the IDLE/WFI decision cycle.
// Backpressure: stall holds fetch/decode/EX for the whole of WFI, TRAP and MRET.
//
// Ports: clk/rst_n (async active-low); csr_valid/csr_we/csr_addr/csr_wdata -> csr_rdata;
//        is_mret/is_wfi from EX; ext_irq/timer_irq level interrupts; pc_next is the
//        resume address saved in mepc; retire counts instructions; stall/redirect/redirect_pc
//        steer the front end.
// Optional: define CSR_COUNTER_EN to add 64-bit mcycle/minstret (0xB00/0xB80, 0xB02/0xB82).
module csr_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_valid,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        is_mret,
    input  logic        is_wfi,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic [31:0] pc_next,
    input  logic        retire,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_WFI, S_TRAP, S_MRET} state_t;

    state_t      state, state_nxt;
    logic        mst_mie, mst_mpie;
    logic        meie, mtie;
    logic        meip, mtip;
    logic [29:0] mtvec_base, mepc_base;
    logic [31:0] mcause;
    logic        irq_pend, irq_take, wr_en;

    // pc_next[1:0] is always dropped (mepc is word aligned); retire only feeds the counters
    logic        unused_bits;
    assign unused_bits = ^{pc_next[1:0], retire};

    // Pending-and-enabled ignores the global MIE; WFI wakes on this alone
    assign irq_pend = (meie & meip) | (mtie & mtip);
    assign irq_take = mst_mie & irq_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        wr_en       = 1'b0;
        case (state)
            S_IDLE: begin
                // A taken interrupt squashes both the CSR write and any MRET/WFI in EX
                wr_en = csr_valid & csr_we & ~irq_take;
                if (irq_take)     state_nxt = S_TRAP;
                else if (is_mret) state_nxt = S_MRET;
                else if (is_wfi)  state_nxt = S_WFI;
            end
            S_WFI: begin
                stall = 1'b1;
                if (irq_pend) state_nxt = irq_take ? S_TRAP : S_IDLE;
            end
            S_TRAP: begin
                stall       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = {mtvec_base, 2'b00};
                state_nxt   = S_IDLE;
            end
            S_MRET: begin
                stall       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = {mepc_base, 2'b00};
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // mip is a plain one-cycle sample of the interrupt lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meip <= 1'b0;
            mtip <= 1'b0;
        end else begin
            meip <= ext_irq;
            mtip <= timer_irq;
        end
    end

    // Trap/MRET side effects land on the edge that leaves those states, so a reset
    // during them leaves nothing half-updated. wr_en is only ever set in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            meie       <= 1'b0;
            mtie       <= 1'b0;
            mtvec_base <= 30'h0;
            mepc_base  <= 30'h0;
            mcause     <= 32'h0;
        end else if (state == S_TRAP) begin
            mepc_base <= pc_next[31:2];
            mcause    <= (meie & meip) ? 32'h8000_000B : 32'h8000_0007;
            mst_mpie  <= mst_mie;
            mst_mie   <= 1'b0;
        end else if (state == S_MRET) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                12'h300: begin
                    mst_mie  <= csr_wdata[3];
                    mst_mpie <= csr_wdata[7];
                end
                12'h304: begin
                    meie <= csr_wdata[11];
                    mtie <= csr_wdata[7];
                end
                12'h305: mtvec_base <= csr_wdata[31:2];
                12'h341: mepc_base  <= csr_wdata[31:2];
                12'h342: mcause     <= csr_wdata;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTER_EN
    logic [63:0] mcycle, minstret;

    // A software write to either half replaces that cycle's increment entirely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle   <= 64'h0;
            minstret <= 64'h0;
        end else begin
            if (wr_en && csr_addr == 12'hB00)      mcycle[31:0]  <= csr_wdata;
            else if (wr_en && csr_addr == 12'hB80) mcycle[63:32] <= csr_wdata;
            else                                   mcycle        <= mcycle + 64'd1;

            if (wr_en && csr_addr == 12'hB02)      minstret[31:0]  <= csr_wdata;
            else if (wr_en && csr_addr == 12'hB82) minstret[63:32] <= csr_wdata;
            else if (retire)                       minstret        <= minstret + 64'd1;
        end
    end
`endif

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            12'h300: csr_rdata = {19'h0, 2'b11, 3'b000, mst_mpie, 3'b000, mst_mie, 3'b000};
            12'h304: csr_rdata = {20'h0, meie, 3'b000, mtie, 7'h0};
            12'h305: csr_rdata = {mtvec_base, 2'b00};
            12'h341: csr_rdata = {mepc_base, 2'b00};
            12'h342: csr_rdata = mcause;
            12'h344: csr_rdata = {20'h0, meip, 3'b000, mtip, 7'h0};
`ifdef CSR_COUNTER_EN
            12'hB00: csr_rdata = mcycle[31:0];
            12'hB80: csr_rdata = mcycle[63:32];
            12'hB02: csr_rdata = minstret[31:0];
            12'hB82: csr_rdata = minstret[63:32];
`endif
            default: csr_rdata = 32'h0;
        endcase
    end

endmodule
